// File: rtl/uc_pkg.sv
// uc_pkg: opcode patterns, decode classes, pc_sel encodings and FSM state for uc_pila
package uc_pkg;
    localparam logic [5:0] OP_ALU  = 6'b0?????;
    localparam logic [5:0] OP_LI   = 6'b10????;
    localparam logic [5:0] OP_JMP  = 6'b1100??;
    localparam logic [5:0] OP_CALL = 6'b1101??;
    localparam logic [5:0] OP_JZ   = 6'b1110??;
    localparam logic [5:0] OP_JNZ  = 6'b11110?;
    localparam logic [5:0] OP_RET  = 6'b111110;
    localparam logic [5:0] OP_RETI = 6'b111111;

    localparam logic [1:0] PC_NEXT = 2'b00;
    localparam logic [1:0] PC_IMM  = 2'b01;
    localparam logic [1:0] PC_RET  = 2'b10;
    localparam logic [1:0] PC_IRQ  = 2'b11;

    localparam logic [2:0] ALU_NONE = 3'b000;

    typedef enum logic {RUN, HALT} state_t;

    typedef enum logic [2:0] {K_ALU, K_LI, K_JMP, K_CALL, K_JZ, K_JNZ, K_RET, K_RETI} kind_t;

    function automatic kind_t decode_op(input logic [5:0] op);
        kind_t k;
        k = K_ALU;
        casez (op)
            OP_ALU:  k = K_ALU;
            OP_LI:   k = K_LI;
            OP_JMP:  k = K_JMP;
            OP_CALL: k = K_CALL;
            OP_JZ:   k = K_JZ;
            OP_JNZ:  k = K_JNZ;
            OP_RET:  k = K_RET;
            default: k = K_RETI;
        endcase
        return k;
    endfunction
endpackage

// File: rtl/pila_dir.sv
// pila_dir: DEPTH x PC_W return-address LIFO; top reads 0 when empty
module pila_dir #(
    parameter int PC_W  = 10,
    parameter int DEPTH = 8,
    parameter int SW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] top,
    output logic [SW-1:0]   sp,
    output logic            full,
    output logic            empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);

    logic [PC_W-1:0] mem [DEPTH];
    logic [SW-1:0]   sp_m1;

    assign full  = sp == DEPTH_S;
    assign empty = sp == '0;
    assign sp_m1 = sp - 1'b1;
    assign top   = empty ? '0 : mem[sp_m1[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            sp <= '0;
        end else if (push && !full) begin
            mem[sp[AW-1:0]] <= din;
            sp <= sp + 1'b1;
        end else if (pop && !empty) begin
            sp <= sp_m1;
        end
    end
endmodule

// File: rtl/uc_pila.sv
// uc_pila: single-cycle CPU control unit with return-address stack and single-level interrupt
module uc_pila
    import uc_pkg::*;
#(
    parameter int PC_W    = 10,
    parameter int DEPTH   = 8,
    parameter int IRQ_VEC = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [5:0]      opcode,
    input  logic            z,
    input  logic [PC_W-1:0] pc,
    input  logic            irq,
    output logic            s_inm,
    output logic            we3,
    output logic            wez,
    output logic [2:0]      op_alu,
    output logic [1:0]      pc_sel,
    output logic            pc_en,
    output logic [PC_W-1:0] ret_addr,
    output logic            in_isr,
    output logic            err
);
    localparam int SW = $clog2(DEPTH + 1);

    state_t          state;
    kind_t           kind;
    logic            run, irq_take, fault, exec, is_rr, push, pop, full, empty;
    logic [1:0]      jsel;
    logic [PC_W-1:0] din;
    logic [SW-1:0]   sp;

    pila_dir #(.PC_W(PC_W), .DEPTH(DEPTH), .SW(SW)) u_pila (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .din(din),
        .top(ret_addr), .sp(sp), .full(full), .empty(empty)
    );

    // An accepted interrupt suppresses the current instruction entirely; faults stall it.
    always_comb begin
        kind     = decode_op(opcode);
        is_rr    = kind == K_RET || kind == K_RETI;
        run      = state == RUN && !reset;
        irq_take = run && irq && !in_isr && !full;
        fault    = run && !irq_take && ((kind == K_CALL && full) || (is_rr && empty));
        exec     = run && !irq_take && !fault;
        jsel     = (kind == K_JMP || kind == K_CALL) ? PC_IMM :
                   (kind == K_JZ)  ? (z ? PC_IMM : PC_NEXT) :
                   (kind == K_JNZ) ? (z ? PC_NEXT : PC_IMM) :
                   is_rr ? PC_RET : PC_NEXT;
        we3      = exec && (kind == K_ALU || kind == K_LI);
        wez      = exec && kind == K_ALU;
        s_inm    = exec && kind == K_LI;
        op_alu   = (exec && kind == K_ALU) ? opcode[4:2] : ALU_NONE;
        pc_en    = run && !fault;
        pc_sel   = irq_take ? PC_IRQ : exec ? jsel : PC_NEXT;
        push     = irq_take || (exec && kind == K_CALL);
        pop      = exec && is_rr;
        din      = irq_take ? pc : pc + PC_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= RUN;
            in_isr <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (fault) begin
                state <= HALT;
                err   <= 1'b1;
            end
            if (irq_take)
                in_isr <= 1'b1;
            else if (pop && kind == K_RETI)
                in_isr <= 1'b0;
        end
    end

    logic unused_vec;
    assign unused_vec = IRQ_VEC[0];
endmodule

// File: tb/tb_uc_pila.sv
// tb_uc_pila: directed checks of decode, call/ret stack, interrupt entry/return and faults
module tb_uc_pila;
    logic       clk = 0, reset = 1, z = 0, irq = 0;
    logic [5:0] opcode = 6'b001100;
    logic [9:0] pc = '0;
    logic       s_inm, we3, wez, pc_en, in_isr, err;
    logic [2:0] op_alu;
    logic [1:0] pc_sel;
    logic [9:0] ret_addr;
    int total = 0, bad = 0;

    localparam logic [5:0] ALU = 6'b001100, CALL = 6'b110100, RET = 6'b111110, RETI = 6'b111111;

    uc_pila dut (
        .clk(clk), .reset(reset), .opcode(opcode), .z(z), .pc(pc), .irq(irq),
        .s_inm(s_inm), .we3(we3), .wez(wez), .op_alu(op_alu), .pc_sel(pc_sel),
        .pc_en(pc_en), .ret_addr(ret_addr), .in_isr(in_isr), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [9:0] p, input logic i);
        opcode = op;
        pc = p;
        irq = i;
        #1;
    endtask

    initial begin
        #1;
        chk("rst_we3", we3, 0);
        chk("rst_pc_en", pc_en, 0);
        chk("rst_pc_sel", pc_sel, 0);
        tick();
        reset = 0;
        chk("rst_in_isr", in_isr, 0);
        chk("rst_err", err, 0);
        chk("rst_ret_addr", ret_addr, 0);

        drive(ALU, 10'h010, 0);
        chk("alu_we3", we3, 1);
        chk("alu_wez", wez, 1);
        chk("alu_op", op_alu, 3'b011);
        chk("alu_pc_sel", pc_sel, 0);
        chk("alu_pc_en", pc_en, 1);
        tick();

        drive(6'b100101, 10'h011, 0);
        chk("li_s_inm", s_inm, 1);
        chk("li_we3", we3, 1);
        chk("li_wez", wez, 0);
        z = 1;
        drive(6'b111001, 10'h011, 0);
        chk("jz_taken", pc_sel, 1);
        z = 0;
        drive(6'b111001, 10'h011, 0);
        chk("jz_not", pc_sel, 0);
        drive(6'b111101, 10'h011, 0);
        chk("jnz_taken", pc_sel, 1);
        drive(6'b110011, 10'h011, 0);
        chk("jmp", pc_sel, 1);
        chk("jmp_we3", we3, 0);

        drive(CALL, 10'h020, 0);
        chk("call_pc_sel", pc_sel, 1);
        chk("call_pc_en", pc_en, 1);
        tick();
        chk("call_ret_addr", ret_addr, 10'h021);
        drive(RET, 10'h030, 0);
        chk("ret_pc_sel", pc_sel, 2);
        tick();
        chk("ret_empty", ret_addr, 0);

        drive(ALU, 10'h055, 1);
        chk("irq_we3", we3, 0);
        chk("irq_wez", wez, 0);
        chk("irq_pc_sel", pc_sel, 3);
        tick();
        chk("irq_ret_addr", ret_addr, 10'h055);
        chk("irq_in_isr", in_isr, 1);
        drive(ALU, 10'h001, 1);
        chk("irq2_we3", we3, 1);
        chk("irq2_pc_sel", pc_sel, 0);
        tick();
        chk("irq2_ret_addr", ret_addr, 10'h055);
        drive(RETI, 10'h002, 0);
        chk("reti_pc_sel", pc_sel, 2);
        tick();
        chk("reti_in_isr", in_isr, 0);
        chk("reti_ret_addr", ret_addr, 0);

        for (int i = 0; i < 8; i++) begin
            drive(CALL, 10'(10'h100 + i), 0);
            chk("nest_pc_en", pc_en, 1);
            tick();
        end
        chk("nest_top", ret_addr, 10'h108);
        drive(CALL, 10'h200, 0);
        chk("ovf_pc_en", pc_en, 0);
        chk("ovf_err_pre", err, 0);
        tick();
        chk("ovf_err", err, 1);
        chk("ovf_top_kept", ret_addr, 10'h108);
        drive(ALU, 10'h201, 1);
        chk("halt_we3", we3, 0);
        chk("halt_wez", wez, 0);
        chk("halt_pc_en", pc_en, 0);
        chk("halt_pc_sel", pc_sel, 0);
        tick();
        chk("halt_in_isr", in_isr, 0);

        reset = 1;
        drive(RET, 10'h000, 0);
        chk("rst_ret_pc_en", pc_en, 0);
        tick();
        reset = 0;
        #1;
        chk("rst_clears_err", err, 0);
        chk("rst_clears_sp", ret_addr, 0);
        chk("unf_pc_en", pc_en, 0);
        tick();
        chk("unf_err", err, 1);
        drive(ALU, 10'h003, 0);
        chk("unf_halt_we3", we3, 0);
        reset = 1;
        tick();
        reset = 0;

        drive(CALL, 10'h3ff, 0);
        tick();
        chk("wrap_ret_addr", ret_addr, 0);
        reset = 1;
        tick();
        reset = 0;

        for (int i = 0; i < 8; i++) begin
            drive(CALL, 10'(10'h140 + i), 0);
            tick();
        end
        drive(ALU, 10'h150, 1);
        chk("defer_we3", we3, 1);
        chk("defer_pc_sel", pc_sel, 0);
        tick();
        chk("defer_in_isr", in_isr, 0);
        drive(RET, 10'h151, 1);
        chk("defer_ret_sel", pc_sel, 2);
        tick();
        chk("defer_pop_top", ret_addr, 10'h147);
        drive(ALU, 10'h148, 1);
        chk("late_irq_sel", pc_sel, 3);
        chk("late_irq_we3", we3, 0);
        tick();
        chk("late_irq_top", ret_addr, 10'h148);
        chk("late_irq_isr", in_isr, 1);
        chk("late_irq_err", err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
